fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the IF/ID latch.
- Owns the PC register and drives the instruction-memory request.
- Produces the word, PC+4, the gated hit and the flush that the IF/ID latch captures.
- Absorbs branch/jump redirects and hazard stalls, and holds redirects that arrive while an imem access is still outstanding.

Parameters:
PC_RESET, 32'h0000_0000, PC value loaded on reset
WORD_W, 32, instruction/address width

Ports:
CLK  in  1  clock; all state updates on the rising edge
RST  in  1  synchronous, active-high reset
ihit  in  1  imem returned imemload for imemaddr this cycle
imemload  in  32  instruction word from imem
imemREN  out  1  imem read enable
imemaddr  out  32  fetch address (= PC register)
stall  in  1  hazard unit: hold PC, do not advance IF/ID
redirect  in  1  resolved branch/jump/jr taken
redirect_pc  in  32  redirect target
halt  in  1  halt retired; stop fetching
imemload_if  out  32  instruction to IF/ID (imemload pass-through)
pcp4_if  out  32  PC+4 to IF/ID
ihit_if  out  1  IF/ID capture enable = ihit & ~stall, or ihit & redirect
flush_if  out  1  IF/ID zeroes its contents on capture

Behaviour:
- Reset (RST=1 at edge):
  - pc <= PC_RESET; state <= RUN; tgt_q <= 0.
  - Outputs after reset: imemREN=1, imemaddr=PC_RESET, flush_if=0.
- imemaddr = pc; imemload_if = imemload, combinational.
- pcp4_if = pc + 4, modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0.
- redirect_pc[1:0] is forced to 2'b00 before use.
- Priority: halt > redirect > stall > sequential advance.
- State RUN:
  - halt: state <= HALTED. flush_if=1 this cycle. pc frozen.
  - redirect & ihit: pc <= redirect_pc. flush_if=1 because the returned word is wrong-path. ihit_if=1 even if stall=1.
  - redirect & ~ihit: tgt_q <= redirect_pc; state <= PEND. pc and imemaddr are held stable until the outstanding access completes.
  - stall (no redirect): pc held; ihit_if=0.
  - otherwise, on ihit: pc <= pc+4. Without ihit: hold.
- State PEND:
  - flush_if=1 every cycle.
  - A new redirect overwrites tgt_q; the latest redirect wins.
  - On ihit: pc <= tgt_q (or redirect_pc if a redirect is present in the same cycle); state <= RUN; ihit_if=1, flush_if=1.
  - stall is ignored in this state.
  - halt takes priority: state <= HALTED.
- State HALTED:
  - imemREN=0, ihit_if=0, flush_if=1, pc frozen.
  - Only RST exits this state.
- RST asserted in any state, including PEND with an access outstanding, discards tgt_q and returns to reset values on the next edge.
- Latency: one cycle from redirect (with ihit) to imemaddr = target.

Optional Feature:
FETCH_CNT_EN
- Defined:
  - Adds output fetch_count [31:0].
  - Increments on every cycle with ihit_if=1 & flush_if=0.
  - Wraps at 2^32; cleared by RST.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg: word_t (logic [WORD_W-1:0]); fetch_state_t enum {RUN, PEND, HALTED}; constant PC_INC = 4.
- Sub-module fetch_ctrl_fsm:
  - Inputs: state register, tgt_q, priority resolution.
  - Outputs: next-pc select, ihit_if, flush_if, imemREN.
  - fetch_unit keeps the pc register and the adder.

Test Plan:
- Reset then ihit=1 for 3 cycles, stall=0 -> imemaddr 0,4,8,C; pcp4_if 4,8,C,10; flush_if=0 throughout.
- At pc=8, redirect=1, redirect_pc=0x40, ihit=1 -> flush_if=1 that cycle; next imemaddr=0x40.
- At pc=8, redirect=1, redirect_pc=0x41, ihit=0 for 2 cycles, then ihit=1 -> imemaddr stays 8, flush_if=1 over all 3 cycles; then imemaddr=0x40 (low bits masked).
- stall=1 for 2 cycles with ihit=1 at pc=0x10 -> imemaddr stays 0x10, ihit_if=0; after release, pc advances to 0x14.
- halt=1 together with redirect=1 -> HALTED: imemREN=0, pc frozen, flush_if=1; RST=1 -> imemaddr=PC_RESET, imemREN=1.
- pc=0xFFFF_FFFC, ihit=1 -> pcp4_if=0, next imemaddr=0. With FETCH_CNT_EN, fetch_count counts non-flushed hits only.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch stage: word type, fetch FSM states, next-pc select.
package cpu_types_pkg;

  localparam int WORD_W = 32;
  localparam int PC_INC = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {RUN, PEND, HALTED} fetch_state_t;

  typedef enum logic [1:0] {PC_HOLD, PC_SEQ, PC_REDIR, PC_TGT} pc_sel_t;

endpackage

// File: rtl/fetch_ctrl_fsm.sv
// Fetch control FSM: resolves halt > redirect > stall > advance and parks
// redirects that arrive while an imem access is still outstanding.
//
//   state  | meaning
//   RUN    | normal fetch; pc advances on each unstalled hit
//   PEND   | redirect taken mid-access; waiting for ihit, then jump to tgt_q
//   HALTED | halt retired; imem idle until reset
module fetch_ctrl_fsm
  import cpu_types_pkg::*;
(
  input  logic    CLK,
  input  logic    RST,
  input  logic    ihit,
  input  logic    stall,
  input  logic    redirect,
  input  word_t   redir_pc,
  input  logic    halt,
  output pc_sel_t pc_sel,
  output word_t   tgt_q,
  output logic    ihit_if,
  output logic    flush_if,
  output logic    imemREN
);

  fetch_state_t state_q, state_d;
  word_t        tgt_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    pc_sel   = PC_HOLD;
    ihit_if  = 1'b0;
    flush_if = 1'b0;
    imemREN  = 1'b1;
    case (state_q)
      RUN: begin
        ihit_if = ihit & (~stall | redirect);
        if (halt) begin
          state_d  = HALTED;
          flush_if = 1'b1;
        end else if (redirect) begin
          flush_if = 1'b1;
          if (ihit) begin
            pc_sel = PC_REDIR;
          end else begin
            tgt_d   = redir_pc;
            state_d = PEND;
          end
        end else if (!stall && ihit) begin
          pc_sel = PC_SEQ;
        end
      end
      PEND: begin
        // Whatever returns here is wrong-path, so every capture is a bubble.
        flush_if = 1'b1;
        ihit_if  = ihit;
        if (halt) begin
          state_d = HALTED;
        end else begin
          if (redirect) tgt_d = redir_pc;
          if (ihit) begin
            pc_sel  = redirect ? PC_REDIR : PC_TGT;
            state_d = RUN;
          end
        end
      end
      HALTED: begin
        imemREN  = 1'b0;
        flush_if = 1'b1;
      end
      default: state_d = RUN;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID latch; owns the PC and its adder.
// Optional FETCH_CNT_EN adds a counter of non-flushed IF/ID captures.
module fetch_unit #(
  parameter int                WORD_W   = 32,
  parameter logic [WORD_W-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic [WORD_W-1:0] imemload,
  output logic              imemREN,
  output logic [WORD_W-1:0] imemaddr,
  input  logic              stall,
  input  logic              redirect,
  input  logic [WORD_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [WORD_W-1:0] imemload_if,
  output logic [WORD_W-1:0] pcp4_if,
  output logic              ihit_if,
  output logic              flush_if
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  import cpu_types_pkg::*;

  logic [WORD_W-1:0] pc_q, pc_d, pcp4, redir_pc, tgt_q;
  pc_sel_t           pc_sel;

  assign redir_pc    = {redirect_pc[WORD_W-1:2], 2'b00};
  assign pcp4        = pc_q + WORD_W'(PC_INC);
  assign imemaddr    = pc_q;
  assign pcp4_if     = pcp4;
  assign imemload_if = imemload;

  fetch_ctrl_fsm u_ctrl (
    .CLK      (CLK),
    .RST      (RST),
    .ihit     (ihit),
    .stall    (stall),
    .redirect (redirect),
    .redir_pc (redir_pc),
    .halt     (halt),
    .pc_sel   (pc_sel),
    .tgt_q    (tgt_q),
    .ihit_if  (ihit_if),
    .flush_if (flush_if),
    .imemREN  (imemREN)
  );

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_SEQ:   pc_d = pcp4;
      PC_REDIR: pc_d = redir_pc;
      PC_TGT:   pc_d = tgt_q;
      default:  pc_d = pc_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) pc_q <= PC_RESET;
    else     pc_q <= pc_d;
  end

`ifdef FETCH_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge CLK) begin
    if (RST)                        cnt_q <= '0;
    else if (ihit_if && !flush_if) cnt_q <= cnt_q + 32'd1;
  end

  assign fetch_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic
// against a behavioural model of the fetch rules.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST, ihit, stall, redirect, halt;
  logic [31:0] imemload, redirect_pc;
  logic        imemREN, ihit_if, flush_if;
  logic [31:0] imemaddr, imemload_if, pcp4_if;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_pc, m_tgt, m_cnt;
  bit          m_halted, m_pending;

  fetch_unit #(.WORD_W(32), .PC_RESET(32'h0000_0000)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .ihit        (ihit),
    .imemload    (imemload),
    .imemREN     (imemREN),
    .imemaddr    (imemaddr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imemload_if (imemload_if),
    .pcp4_if     (pcp4_if),
    .ihit_if     (ihit_if),
    .flush_if    (flush_if)
`ifdef FETCH_CNT_EN
    ,
    .fetch_count (fetch_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", tag, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare settled outputs, advance model at posedge.
  task automatic step(input logic i_rst, input logic i_ihit, input logic i_stall,
                      input logic i_redir, input logic [31:0] i_rpc,
                      input logic i_halt, input bit do_chk);
    logic        e_ihit_if, e_flush;
    logic [31:0] tgt;
    @(negedge CLK);
    RST = i_rst; ihit = i_ihit; stall = i_stall; redirect = i_redir;
    redirect_pc = i_rpc; halt = i_halt; imemload = $urandom;
    #1;
    tgt = i_rpc & 32'hFFFF_FFFC;
    if (m_halted) begin
      e_ihit_if = 1'b0; e_flush = 1'b1;
    end else if (m_pending) begin
      e_ihit_if = i_ihit; e_flush = 1'b1;
    end else begin
      e_ihit_if = i_ihit && (!i_stall || i_redir);
      e_flush   = i_halt || i_redir;
    end
    if (do_chk) begin
      check("imemaddr", imemaddr, m_pc);
      check("pcp4_if", pcp4_if, m_pc + 32'd4);
      check("imemload_if", imemload_if, imemload);
      check("imemREN", {31'd0, imemREN}, {31'd0, !m_halted});
      check("ihit_if", {31'd0, ihit_if}, {31'd0, e_ihit_if});
      check("flush_if", {31'd0, flush_if}, {31'd0, e_flush});
`ifdef FETCH_CNT_EN
      check("fetch_count", fetch_count, m_cnt);
`endif
    end
    @(posedge CLK);
    if (i_rst) begin
      m_pc = 32'h0; m_tgt = 32'h0; m_cnt = 32'h0; m_halted = 0; m_pending = 0;
    end else begin
      if (e_ihit_if && !e_flush) m_cnt = m_cnt + 32'd1;
      if (m_halted) begin
      end else if (i_halt) begin
        m_halted = 1; m_pending = 0;
      end else if (m_pending) begin
        if (i_redir) m_tgt = tgt;
        if (i_ihit) begin
          m_pc = m_tgt; m_pending = 0;
        end
      end else if (i_redir) begin
        if (i_ihit) m_pc = tgt;
        else begin
          m_tgt = tgt; m_pending = 1;
        end
      end else if (!i_stall && i_ihit) begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic run_hits(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    RST = 1; ihit = 0; stall = 0; redirect = 0; halt = 0;
    imemload = 0; redirect_pc = 0;
    m_pc = 0; m_tgt = 0; m_cnt = 0; m_halted = 0; m_pending = 0;

    // Sequential fetch from reset
    do_reset();
    #2;
    check("rst_addr", imemaddr, 32'h0);
    check("rst_ren", {31'd0, imemREN}, 32'd1);
    check("rst_flush", {31'd0, flush_if}, 32'd0);
    run_hits(3);
    #2 check("seq_addr_c", imemaddr, 32'hC);

    // Redirect with ihit at pc=8
    do_reset();
    run_hits(2);
    step(0, 1, 0, 1, 32'h40, 0, 1);
    #2 check("redir_hit_addr", imemaddr, 32'h40);
    run_hits(1);

    // Redirect while access outstanding, target low bits masked
    do_reset();
    run_hits(2);
    step(0, 0, 0, 1, 32'h41, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
    #2 check("pend_addr_hold", imemaddr, 32'h8);
    step(0, 1, 0, 0, 0, 0, 1);
    #2 check("pend_addr_tgt", imemaddr, 32'h40);
    run_hits(1);

    // Latest redirect wins while pending, plus stall ignored
    step(0, 0, 0, 1, 32'h100, 0, 1);
    step(0, 0, 1, 1, 32'h200, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    #2 check("pend_latest", imemaddr, 32'h200);

    // Stall at pc=0x10
    do_reset();
    run_hits(4);
    step(0, 1, 1, 0, 0, 0, 1);
    step(0, 1, 1, 0, 0, 0, 1);
    #2 check("stall_hold", imemaddr, 32'h10);
    run_hits(1);
    #2 check("stall_release", imemaddr, 32'h14);

    // Halt beats redirect; only reset leaves HALTED
    step(0, 1, 0, 1, 32'h80, 1, 1);
    run_hits(2);
    step(0, 1, 0, 1, 32'h80, 0, 1);
    #2;
    check("halt_ren", {31'd0, imemREN}, 32'd0);
    check("halt_pc", imemaddr, 32'h14);
    do_reset();
    #2;
    check("unhalt_addr", imemaddr, 32'h0);
    check("unhalt_ren", {31'd0, imemREN}, 32'd1);

    // Reset from PEND discards the parked target
    step(0, 0, 0, 1, 32'h300, 0, 1);
    do_reset();
    run_hits(1);
    #2 check("rst_pend_addr", imemaddr, 32'h4);

    // PC wrap at top of address space
    step(0, 1, 0, 1, 32'hFFFF_FFFC, 0, 1);
    #2 check("wrap_pcp4", pcp4_if, 32'h0);
    run_hits(1);
    #2 check("wrap_addr", imemaddr, 32'h0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 70),
           ($urandom_range(99) < 20), ($urandom_range(99) < 12),
           $urandom, ($urandom_range(199) < 2), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
